demux_reassembler: RTL and testbench
====================================

// Module: demux_reassembler
// PURPOSE
//   Inverse of the halving mux: accepts NUM_OUTPUTS/2-bit half-words tagged by sel
//   and rebuilds the full NUM_OUTPUTS-bit word. The low half (sel=0) arrives first,
//   then the high half (sel=1). Sits on the receive side of the narrow CDC data path,
//   after the synchronizer, with valid/ready handshakes on both sides.
// PARAMETERS
//   NUM_OUTPUTS  16  full word width; must be even and >=2 (elaboration $error otherwise)
// PORTS
//   clk        in   1              single clock; all logic rising-edge
//   rst_n      in   1              asynchronous, active-low reset
//   in_data    in   NUM_OUTPUTS/2  half-word payload
//   in_sel     in   1              0 = low half [NUM_OUTPUTS/2-1:0], 1 = high half
//   in_valid   in   1              in_data/in_sel valid
//   in_ready   out  1              block accepts the half-word this cycle
//   out_data   out  NUM_OUTPUTS    reassembled word {hi,lo}
//   out_valid  out  1              out_data valid; held until out_ready
//   out_ready  in   1              downstream accepts out_data
//   seq_err    out  1              one-cycle pulse on an out-of-order half
//   err_count  out  8              saturating error count (DEMUX_ERRCNT_EN only)
// BEHAVIOUR
//   Reset: state=EXP_LO, out_data=0, out_valid=0, seq_err=0, err_count=0. in_ready is
//     combinational and equals 1 after reset.
//   Accept = in_valid & in_ready; output xfer = out_valid & out_ready.
//   FSM (registered), all transitions on accept and/or xfer:
//     EXP_LO : accept sel=0 -> latch lo, go EXP_HI.
//              accept sel=1 -> drop, seq_err=1 next cycle, stay.
//     EXP_HI : accept sel=1 -> out_data<={in_data,lo}, out_valid<=1, go FULL.
//              accept sel=0 -> overwrite lo, seq_err=1, stay EXP_HI (restart word).
//     FULL   : in_ready = out_ready (pass-through: no bubble).
//              xfer, no accept -> out_valid<=0, go EXP_LO.
//              xfer + accept sel=0 -> latch lo, out_valid<=0, go EXP_HI.
//              xfer + accept sel=1 -> drop, seq_err=1, out_valid<=0, go EXP_LO.
//              no xfer -> hold out_data/out_valid stable, in_ready=0.
//   in_ready = 1 in EXP_LO and EXP_HI.
//   Latency: out_valid asserts the cycle after the high half is accepted. Throughput:
//     one word per 2 cycles sustained.
//   out_data changes only on entry to FULL. Input while in_valid=0 is ignored.
//   Async reset mid-word discards the partial word with no seq_err. NUM_OUTPUTS=2 gives
//     1-bit halves; the behaviour is otherwise identical.
// CONFIGURATION
//   DEMUX_ERRCNT_EN defined: err_count port present. It increments on every seq_err
//     pulse and saturates at 8'hFF. Reset is the only clear.
//   Undefined: err_count port and counter absent; seq_err is unchanged.
// STRUCTURE
//   demux_pkg: typedef enum logic [1:0] {EXP_LO, EXP_HI, FULL} demux_state_t;
//     localparam ERRCNT_W = 8.
//   Sub-module demux_err_counter (saturating counter) is instantiated only under
//     DEMUX_ERRCNT_EN. The FSM and half-word registers stay in demux_reassembler.
// TESTING (NUM_OUTPUTS=16)
//   1. Reset: rst_n=0 -> out_valid=0, out_data=0, in_ready=1, seq_err=0, err_count=0.
//   2. Normal: lo=8'hAA sel0, then hi=8'h55 sel1, out_ready=1 -> out_data=16'h55AA with
//      out_valid for exactly 1 cycle, starting 1 cycle after the hi accept.
//   3. Backpressure: out_ready=0 after 16'h55AA -> out_valid and data hold, in_ready=0.
//      Next lo 8'h01 is not accepted until out_ready=1. Then 8'h01/8'h02 -> 16'h0201.
//   4. Order error: sel1 8'h33 first -> seq_err pulse, dropped. Then lo 8'h11, lo 8'h22,
//      hi 8'h44 -> second seq_err pulse; out_data=16'h4422.
//   5. Back-to-back: in_valid=1 continuously, alternating sel, out_ready=1 for
//      words 16'h0201,16'h0403,16'h0605 -> one word per 2 cycles, no seq_err.
//   6. Reset mid-word: lo 8'hF0 accepted, rst_n pulse low -> EXP_LO. hi 8'h0F -> seq_err.
//      With DEMUX_ERRCNT_EN, 300 sel1-only accepts -> err_count=8'hFF.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared types and constants for the half-word demux/reassembler.
//   demux_state_t : reassembly FSM state
//   ERRCNT_W      : width of the optional sequence-error counter
package demux_pkg;

  typedef enum logic [1:0] {
    EXP_LO = 2'd0,
    EXP_HI = 2'd1,
    FULL   = 2'd2
  } demux_state_t;

  localparam int unsigned ERRCNT_W = 8;

endpackage

// File: rtl/demux_err_counter.sv
// Saturating event counter for sequence errors.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (only clear)
//   inc        : count one event this cycle
//   count      : current count, sticks at all-ones
module demux_err_counter
  import demux_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                inc,
  output logic [ERRCNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + ERRCNT_W'(1);
    end
  end

endmodule

// File: rtl/demux_reassembler.sv
// Rebuilds NUM_OUTPUTS-bit words from half-words tagged by in_sel (low half
// first, then high half), with valid/ready handshakes on both sides.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_data/in_sel       : half-word payload and half select (0 = low, 1 = high)
//   in_valid/in_ready    : input handshake (in_ready is combinational)
//   out_data             : reassembled word {hi, lo}
//   out_valid/out_ready  : output handshake; out_data held until taken
//   seq_err              : one-cycle pulse on an out-of-order half
//   err_count            : saturating error count, present only when the
//                          DEMUX_ERRCNT_EN macro is defined
module demux_reassembler
  import demux_pkg::*;
#(
  parameter int unsigned NUM_OUTPUTS = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_OUTPUTS/2-1:0] in_data,
  input  logic                     in_sel,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [NUM_OUTPUTS-1:0]   out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     seq_err
`ifdef DEMUX_ERRCNT_EN
  ,
  output logic [ERRCNT_W-1:0]      err_count
`endif
);

  localparam int unsigned HALF_W = NUM_OUTPUTS / 2;

  if ((NUM_OUTPUTS < 2) || ((NUM_OUTPUTS % 2) != 0)) begin : g_bad_width
    $error("demux_reassembler: NUM_OUTPUTS must be even and >= 2");
  end

  demux_state_t      state;
  logic [HALF_W-1:0] lo;
  logic              accept;
  logic              xfer;

  // FULL passes out_ready through so a new low half can land in the same
  // cycle the finished word leaves.
  assign in_ready = (state != FULL) || out_ready;
  assign accept   = in_valid && in_ready;
  assign xfer     = out_valid && out_ready;

  // Reassembly FSM with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= EXP_LO;
      lo        <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      seq_err   <= 1'b0;
    end else begin
      seq_err <= 1'b0;
      case (state)
        EXP_LO: begin
          if (accept) begin
            if (!in_sel) begin
              lo    <= in_data;
              state <= EXP_HI;
            end else begin
              seq_err <= 1'b1;
            end
          end
        end
        EXP_HI: begin
          if (accept) begin
            if (in_sel) begin
              out_data  <= {in_data, lo};
              out_valid <= 1'b1;
              state     <= FULL;
            end else begin
              // A second low half restarts the word.
              lo      <= in_data;
              seq_err <= 1'b1;
            end
          end
        end
        FULL: begin
          if (xfer) begin
            out_valid <= 1'b0;
            if (accept && !in_sel) begin
              lo    <= in_data;
              state <= EXP_HI;
            end else begin
              if (accept) begin
                seq_err <= 1'b1;
              end
              state <= EXP_LO;
            end
          end
        end
        default: begin
          state     <= EXP_LO;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef DEMUX_ERRCNT_EN
  demux_err_counter u_err_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (seq_err),
    .count (err_count)
  );
`endif

endmodule

// File: tb/tb_demux_reassembler.sv
// Scoreboard bench for demux_reassembler (NUM_OUTPUTS = 16).
// The driver issues directed and random half-words; the reference model
// tracks "a low half is pending" and "a finished word is waiting", pushes each
// completed word onto a queue, and the monitor pops and compares whenever the
// DUT presents out_valid.
module tb_demux_reassembler;

  localparam int unsigned N    = 16;
  localparam int unsigned HALF = N / 2;

  logic            clk;
  logic            rst_n;
  logic [HALF-1:0] in_data;
  logic            in_sel;
  logic            in_valid;
  logic            in_ready;
  logic [N-1:0]    out_data;
  logic            out_valid;
  logic            out_ready;
  logic            seq_err;
`ifdef DEMUX_ERRCNT_EN
  logic [7:0]      err_count;
`endif

  demux_reassembler #(.NUM_OUTPUTS(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .seq_err   (seq_err)
`ifdef DEMUX_ERRCNT_EN
    ,
    .err_count (err_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [N-1:0]    exp_q[$];
  logic            have_lo;
  logic [HALF-1:0] lo_val;
  logic            m_full;
  logic            exp_err;
  int              m_cnt;
  logic            m_ready;
  logic            m_xfer;
  logic            m_e;
  // Monitor state
  logic            cur_loaded;
  logic [N-1:0]    cur_word;
  logic [N-1:0]    last_word;
  logic            done;
  logic            final_done;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    have_lo    = 1'b0;
    lo_val     = '0;
    m_full     = 1'b0;
    exp_err    = 1'b0;
    m_cnt      = 0;
    cur_loaded = 1'b0;
    cur_word   = '0;
    last_word  = '0;
  endtask

  // Model update on the rising edge, comparison on the falling edge.
  initial begin
    model_reset();
    final_done = 1'b0;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        model_reset();
      end else begin
        if (exp_err && (m_cnt < 255)) m_cnt++;
        m_ready = !m_full || out_ready;
        m_xfer  = m_full && out_ready;
        m_e     = 1'b0;
        if (m_xfer) m_full = 1'b0;
        if (in_valid && m_ready) begin
          if (!in_sel) begin
            if (have_lo) m_e = 1'b1;
            have_lo = 1'b1;
            lo_val  = in_data;
          end else if (have_lo) begin
            exp_q.push_back({in_data, lo_val});
            have_lo = 1'b0;
            m_full  = 1'b1;
          end else begin
            m_e = 1'b1;
          end
        end
        exp_err = m_e;
      end

      @(negedge clk);
      if (!rst_n) begin
        model_reset();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_seq_err", 32'(seq_err), 32'd0);
`ifdef DEMUX_ERRCNT_EN
        check("rst_err_count", 32'(err_count), 32'd0);
`endif
      end else begin
        check("in_ready", 32'(in_ready), 32'(!m_full || out_ready));
        check("out_valid", 32'(out_valid), 32'(m_full));
        check("seq_err", 32'(seq_err), 32'(exp_err));
`ifdef DEMUX_ERRCNT_EN
        check("err_count", 32'(err_count), 32'(m_cnt));
`endif
        if (out_valid) begin
          if (!cur_loaded) begin
            if (exp_q.size() == 0) begin
              check("unexpected_word", 32'(out_valid), 32'd0);
            end else begin
              cur_word   = exp_q.pop_front();
              last_word  = cur_word;
              cur_loaded = 1'b1;
            end
          end
          if (cur_loaded) check("out_data", 32'(out_data), 32'(cur_word));
          if (out_ready) cur_loaded = 1'b0;
        end else begin
          check("out_data_stable", 32'(out_data), 32'(last_word));
        end
        if (done && !final_done) begin
          check("sb_drained", 32'(exp_q.size()), 32'd0);
          final_done = 1'b1;
        end
      end
    end
  end

  task automatic drive(input logic v, input logic s, input logic [HALF-1:0] d, input logic r);
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    done      = 1'b0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sel    = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (3) drive(1'b0, 1'b0, 8'h00, 1'b1);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 1'b1);

    // Normal word
    drive(1'b1, 1'b0, 8'hAA, 1'b1);
    drive(1'b1, 1'b1, 8'h55, 1'b1);
    repeat (2) drive(1'b0, 1'b0, 8'h00, 1'b1);

    // Backpressure, then pass-through accept of the next low half
    drive(1'b1, 1'b0, 8'hAA, 1'b0);
    drive(1'b1, 1'b1, 8'h55, 1'b0);
    repeat (3) drive(1'b1, 1'b0, 8'h01, 1'b0);
    drive(1'b1, 1'b0, 8'h01, 1'b1);
    drive(1'b1, 1'b1, 8'h02, 1'b1);
    repeat (2) drive(1'b0, 1'b0, 8'h00, 1'b1);

    // Order errors
    drive(1'b1, 1'b1, 8'h33, 1'b1);
    drive(1'b1, 1'b0, 8'h11, 1'b1);
    drive(1'b1, 1'b0, 8'h22, 1'b1);
    drive(1'b1, 1'b1, 8'h44, 1'b1);
    repeat (2) drive(1'b0, 1'b0, 8'h00, 1'b1);

    // Back-to-back words
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 1'b0, 8'(2 * i - 1), 1'b1);
      drive(1'b1, 1'b1, 8'(2 * i), 1'b1);
    end
    repeat (2) drive(1'b0, 1'b0, 8'h00, 1'b1);

    // Reset mid-word drops the pending low half silently
    drive(1'b1, 1'b0, 8'hF0, 1'b1);
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 8'h0F, 1'b1);
    repeat (2) drive(1'b0, 1'b0, 8'h00, 1'b1);

    // Long run of high halves only: error counter saturation
    repeat (300) drive(1'b1, 1'b1, 8'($urandom_range(0, 255)), 1'b1);
    repeat (3) drive(1'b0, 1'b0, 8'h00, 1'b1);

    // Random traffic with random backpressure
    repeat (1500) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            8'($urandom_range(0, 255)), 1'($urandom_range(0, 3) != 0));
    end

    // Drain
    repeat (3) drive(1'b0, 1'b0, 8'h00, 1'b1);
    done = 1'b1;
    repeat (3) drive(1'b0, 1'b0, 8'h00, 1'b1);
    if (!final_done) check("final_check_reached", 32'(final_done), 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
